// File: rtl/ex_muldiv_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide unit.
// The pipeline side drives requests through master; the unit answers through slave.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers.
// Works on magnitudes for WIDTH cycles, then applies the result signs in a single fix-up cycle.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         clr_n,
    ex_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic               done_q;
    logic               dz_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign a_neg = bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = bus.op[0] & bus.b[WIDTH-1];
    assign a_abs = a_neg ? -bus.a : bus.a;
    assign b_abs = b_neg ? -bus.b : bus.b;

    // Multiply keeps the multiplier in the low half; divide keeps the partial remainder in the high half.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, opb};
    assign q_bit   = ~diff[WIDTH];
    assign step    = is_div ? {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit}
                            : {mul_sum, acc[WIDTH-1:1]};

    assign prod = neg_q ? -acc : acc;
    assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start && !bus.flush) state_nxt = RUN;
            RUN: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc    <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A start shadows any move issued in the same cycle, even when flush drops the start.
                    if (bus.start) begin
                        if (!bus.flush) begin
                            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
                            opb    <= bus.op[1] ? b_abs : a_abs;
                            cnt    <= '0;
                            is_div <= bus.op[1];
                            neg_q  <= (a_neg ^ b_neg) & ~(bus.op[1] & (bus.b == '0));
                            neg_r  <= a_neg;
                            b_zero <= (bus.b == '0);
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.a;
                        if (bus.mtlo) lo_q <= bus.a;
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        acc <= step;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_q   <= is_div ? rem  : prod[2*WIDTH-1:WIDTH];
                        lo_q   <= is_div ? quot : prod[WIDTH-1:0];
                        dz_q   <= is_div & b_zero;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit for the execute stage of the five-stage MIPS pipeline. It consumes the operand values and control decoded into the decode/execute pipeline register and computes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. It uses a 32-iteration shift-add / restoring-division datapath. The hazard unit stalls fetch/decode/execute on `busy`, and MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits. Iteration count equals `WIDTH`.
- `clk` in 1: pipeline clock; all state changes on the rising edge.
- `clr_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a new operation; sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; captured with `start`.
- `a` in WIDTH: rs value (multiplicand / dividend); captured with `start`.
- `b` in WIDTH: rt value (multiplier / divisor); captured with `start`.
- `mthi` in 1: write `a` into HI (MTHI); IDLE only.
- `mtlo` in 1: write `a` into LO (MTLO); IDLE only.
- `flush` in 1: abort an in-flight operation.
- `busy` out 1: operation in progress; hazard unit stalls on it.
- `done` out 1: one-cycle pulse; HI/LO were updated by a completed operation on this edge.
- `div_zero` out 1: registered flag; the last completed divide had `b == 0`.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Reset (`clr_n` low, asynchronous):
  - state IDLE.
  - `hi`, `lo` = 0.
  - `busy`, `done`, `div_zero` = 0.
  - iteration counter and working registers = 0.
- States:
  - IDLE: `start` loads the operands and goes to RUN. Signed ops load |a| and |b| and latch the result-sign bits.
  - RUN: one iteration per cycle, counter 0..WIDTH-1. After iteration WIDTH-1, go to FIX.
  - FIX: apply signs, write HI/LO, go to IDLE.
- Multiply: 2*WIDTH-bit accumulator using shift-add on |a|·|b|.
  - MULT negates the product when `a[WIDTH-1]` ^ `b[WIDTH-1]`.
  - HI = product[2W-1:W], LO = product[W-1:0].
- Divide: restoring division on |a|/|b|.
  - LO = quotient, HI = remainder.
  - DIV negates the quotient when the signs differ; the remainder takes the sign of `a`.
  - `b == 0`: the datapath result stands. LO = 0xFFFFFFFF, HI = |a| with the sign fix applied. `div_zero` is set.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, no trap.
- `div_zero` updates only in FIX: set for a divide by zero, cleared for any other completed op.
- `mthi`/`mtlo` in IDLE write `a` on the next edge. Both asserted together write both.
- `start` together with `mthi`/`mtlo` in the same IDLE cycle: `start` wins and the move is dropped.
- `start`, `mthi`, `mtlo` while `busy`: ignored. The hazard unit never issues these.
- `flush` in RUN or FIX: return to IDLE on the next edge.
  - HI/LO and `div_zero` are unchanged and no `done` pulse is produced.
  - `flush` in IDLE takes priority over `start`, so the start is dropped.

## Timing
- `start` sampled at edge E0.
- `busy` is high after edges E0..E(W) (W+1 cycles); it is combinationally `state != IDLE`.
- `hi`/`lo` take the new value at edge E(W+1). `done` is high for exactly the cycle after E(W+1), and `busy` is low in that cycle.
- With W=32: results at E33.
- A new `start` is accepted in the `done` cycle, giving back-to-back operations every 34 cycles.
- `mthi`/`mtlo` latency: 1 edge.
- `clr_n` low mid-RUN: the outputs go to their reset values immediately, independent of `clk`. Operation resumes from IDLE after release.

## Test plan
- Reset, then MULTU with `a` = 0xFFFFFFFF, `b` = 0xFFFFFFFF:
  - `busy` high for 33 cycles.
  - `done` one cycle.
  - HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT with `a` = 0xFFFFFFFD (-3), `b` = 5: HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIV with `a` = 0xFFFFFFF9 (-7), `b` = 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, `div_zero` = 0.
- DIVU with `a` = 100, `b` = 0: LO = 0xFFFFFFFF, HI = 0x00000064, `div_zero` = 1.
  - A following MULTU 2×3 gives HI = 0, LO = 6 and clears `div_zero`.
- MTHI with `a` = 0x12345678, then MTLO with `a` = 0x9ABCDEF0: `hi`/`lo` update one edge after each.
  - `start` together with `mthi`: the move is dropped.
- Start a DIVU, then abort at RUN cycle 10:
  - Abort with `flush`: prior HI/LO are kept, no `done` pulse, IDLE next cycle.
  - Abort by dropping `clr_n` low instead: HI = LO = 0 and `busy` = 0 immediately, without waiting for a clock edge.
